// File: rtl/cpu_reset_pkg.sv
// cpu_reset_pkg: shared constants for the Z80 reset conditioning block.
`default_nettype none

package cpu_reset_pkg;

    localparam int STRETCH_CYCLES_DEFAULT = 3;
    localparam int CNT_W                  = 4;
    localparam int MAX_STRETCH            = 15;

endpackage

`default_nettype wire

// File: rtl/reset_sync.sv
// reset_sync: 2-flop asynchronous-assert, synchronous-release reset synchronizer.
`default_nettype none

module reset_sync (
    input  logic clk,
    input  logic arst_n_i,
    output logic sync_n_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= 1'b1;
            ff2_q <= ff1_q;
        end
    end

    assign sync_n_o = ff2_q;

endmodule

`default_nettype wire

// File: rtl/cpu_reset.sv
// cpu_reset: Z80 reset conditioning (async assert, stretched sync release, clrpc hold).
// Optional macro RESET_SYNC_EN inserts a 2-flop release synchronizer ahead of the stretch counter.
`default_nettype none

module cpu_reset
    import cpu_reset_pkg::*;
#(
    parameter int STRETCH_CYCLES = STRETCH_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic nreset_in,
    input  logic M1,
    input  logic T2,
    output logic clrpc,
    output logic reset,
    output logic nreset
);

    localparam logic [CNT_W-1:0] STRETCH_VAL = CNT_W'(STRETCH_CYCLES);

    if (STRETCH_CYCLES < 1 || STRETCH_CYCLES > MAX_STRETCH) begin : g_bad_stretch
        $error("cpu_reset: STRETCH_CYCLES out of range 1..15");
    end

    logic             pin_ok;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             reset_q,  reset_d;
    logic             nreset_q;
    logic             clrpc_q,  clrpc_d;

`ifdef RESET_SYNC_EN
    reset_sync u_reset_sync (
        .clk      (clk),
        .arst_n_i (nreset_in),
        .sync_n_o (pin_ok)
    );
`else
    assign pin_ok = nreset_in;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        clrpc_d = clrpc_q;
        if (!pin_ok) begin
            cnt_d = '0;
        end else if (cnt_q != STRETCH_VAL) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Release happens on the very edge the counter lands on the target.
        reset_d = (cnt_d != STRETCH_VAL);
        // Uses the pre-edge reset value, so an M1/T2 during the stretch cannot clear.
        if (reset_q) begin
            clrpc_d = 1'b1;
        end else if (M1 && T2) begin
            clrpc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset_in) begin
        if (!nreset_in) begin
            cnt_q    <= '0;
            reset_q  <= 1'b1;
            nreset_q <= 1'b0;
            clrpc_q  <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            reset_q  <= reset_d;
            nreset_q <= ~reset_d;
            clrpc_q  <= clrpc_d;
        end
    end

    assign reset  = reset_q;
    assign nreset = nreset_q;
    assign clrpc  = clrpc_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_reset.sv
// tb_cpu_reset: directed self-checking bench for cpu_reset (STRETCH_CYCLES = 3, no synchronizer).
`default_nettype none

module tb_cpu_reset;

    logic clk       = 1'b0;
    logic clk_en    = 1'b0;
    logic nreset_in = 1'b1;
    logic M1        = 1'b0;
    logic T2        = 1'b0;
    logic clrpc;
    logic reset;
    logic nreset;

    int checks   = 0;
    int failures = 0;

    cpu_reset #(.STRETCH_CYCLES(3)) dut (
        .clk       (clk),
        .nreset_in (nreset_in),
        .M1        (M1),
        .T2        (T2),
        .clrpc     (clrpc),
        .reset     (reset),
        .nreset    (nreset)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic e_rst, input logic e_clrpc);
        check({tag, "_reset"},  reset,  e_rst);
        check({tag, "_nreset"}, nreset, ~e_rst);
        check({tag, "_clrpc"},  clrpc,  e_clrpc);
    endtask

    initial begin
        // Power-up: pin asserted with the clock stopped.
        #1 nreset_in = 1'b0;
        #1 check_all("powerup", 1'b1, 1'b1);

        clk_en = 1'b1;
        repeat (3) tick();
        check_all("held_low", 1'b1, 1'b1);

        // Normal release: reset falls on the 3rd edge sampling the pin high.
        nreset_in = 1'b1;
        tick(); check_all("rel_e1", 1'b1, 1'b1);
        tick(); check_all("rel_e2", 1'b1, 1'b1);
        tick(); check_all("rel_e3", 1'b0, 1'b1);
        tick(); check_all("rel_e4_m1lo", 1'b0, 1'b1);

        // clrpc clear on M1/T2.
        M1 = 1'b1; T2 = 1'b1;
        tick(); check("clr_edge", clrpc, 1'b0);
        M1 = 1'b0; T2 = 1'b0;
        tick(); check("clr_stay", clrpc, 1'b0);
        M1 = 1'b1; T2 = 1'b1;
        tick(); check_all("clr_noeffect", 1'b0, 1'b0);

        // Brief pulse during M1/T1.
        T2 = 1'b0;
        nreset_in = 1'b0;
        #1 check_all("pulse_async", 1'b1, 1'b1);
        tick();
        nreset_in = 1'b1; T2 = 1'b1;
        tick(); check_all("pulse_t2_first", 1'b1, 1'b1);
        T2 = 1'b0;
        tick(); check_all("pulse_d", 1'b1, 1'b1);
        tick(); check_all("pulse_e", 1'b0, 1'b1);
        tick(); tick(); check_all("pulse_g", 1'b0, 1'b1);
        T2 = 1'b1;
        tick(); check_all("pulse_t2_second", 1'b0, 1'b0);
        M1 = 1'b0; T2 = 1'b0;

        // Full reset, then a short glitch one edge into the stretch.
        nreset_in = 1'b0;
        tick();
        nreset_in = 1'b1;
        tick(); check("str_e1", reset, 1'b1);
        nreset_in = 1'b0;
        #2 check_all("str_glitch", 1'b1, 1'b1);
        nreset_in = 1'b1;
        tick(); check("str_r1", reset, 1'b1);
        tick(); check("str_r2", reset, 1'b1);
        tick(); check_all("str_r3", 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
